// File: rtl/biu_pkg.sv
// Shared types and encodings for the 8088 bus interface unit controller:
// bus cycle states, segment selects and address-generator OP codes.
package biu_pkg;

    typedef enum logic [2:0] {
        BUS_TI = 3'd0,
        BUS_T1 = 3'd1,
        BUS_T2 = 3'd2,
        BUS_T3 = 3'd3,
        BUS_TW = 3'd4,
        BUS_T4 = 3'd5
    } bus_state_t;

    localparam logic [1:0] SEG_CS = 2'b00;
    localparam logic [1:0] SEG_DS = 2'b01;
    localparam logic [1:0] SEG_SS = 2'b10;
    localparam logic [1:0] SEG_ES = 2'b11;

    localparam logic [2:0] OP_SEG_IP        = 3'b000;
    localparam logic [2:0] OP_SEG_REL       = 3'b001;
    localparam logic [2:0] OP_SEG_R1        = 3'b010;
    localparam logic [2:0] OP_SEG_R1_REL    = 3'b011;
    localparam logic [2:0] OP_SEG_R1_R2     = 3'b100;
    localparam logic [2:0] OP_SEG_R1_R2_REL = 3'b101;

    localparam int Q_CNT_W = 3;

endpackage

// File: rtl/biu_queue_tracker.sv
// Prefetch queue occupancy counter. Flush beats everything, a simultaneous
// push and pop cancel out, and a pop on an empty queue is ignored.
module biu_queue_tracker #(
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next occupancy in priority order; the arbiter looks at this value.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push_i && pop_i) begin
            count_d = count_q;
        end else if (push_i && (count_q != CNT_W'(QUEUE_DEPTH))) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/biu_bus_controller.sv
// 8088 BIU sequencer: runs T1..T4 (+TW) bus cycles, gives EU requests
// priority over prefetch and drives the datapath selects and bus strobes.
module biu_bus_controller
    import biu_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int MAX_WAIT    = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         eu_req,
    input  logic         eu_we,
    input  logic [2:0]   eu_op,
    input  logic [1:0]   eu_seg,
    input  logic [7:0]   eu_wdata,
    output logic [7:0]   eu_rdata,
    output logic         eu_done,
    input  logic         q_pop,
    input  logic         q_flush,
    output logic [2:0]   q_count,
    input  logic         ready,
    input  logic [7:0]   bus_rdata,
    output logic [7:0]   bus_wdata,
    output logic         ale,
    output logic         rd_n,
    output logic         wr_n,
    output logic [2:0]   addr_op,
    output logic [1:0]   seg_sel,
    output logic         ip_en,
    output logic         ip_sel,
    output logic         q_push,
    output logic         internal_rd_wr,
    output logic [2:0]   bus_state,
    output logic         bus_err
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    bus_state_t          state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                is_eu_q, is_eu_d;
    logic                we_q, we_d;
    logic                flushed_q, flushed_d;
    logic [2:0]          addr_op_q, addr_op_d;
    logic [1:0]          seg_sel_q, seg_sel_d;
    logic [7:0]          bus_wdata_q, bus_wdata_d;
    logic [7:0]          eu_rdata_q, eu_rdata_d;
    logic                ale_q, ale_d;
    logic                rd_n_q, rd_n_d;
    logic                wr_n_q, wr_n_d;
    logic                q_push_q, q_push_d;
    logic                ip_en_q, ip_en_d;
    logic                eu_done_q, eu_done_d;
    logic                bus_err_q, bus_err_d;
    logic [Q_CNT_W-1:0]  q_count_next_s;
    logic                arb_s, finish_s, timeout_s, strobe_s, pf_ok_s;

    biu_queue_tracker #(
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .CNT_W       (Q_CNT_W)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .push_i       (q_push_q),
        .pop_i        (q_pop),
        .flush_i      (q_flush),
        .count_o      (q_count),
        .count_next_o (q_count_next_s)
    );

    assign pf_ok_s = (q_count_next_s < Q_CNT_W'(QUEUE_DEPTH)) && !q_flush;

    // Bus cycle sequencing, arbitration and registered output decode.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        is_eu_d     = is_eu_q;
        we_d        = we_q;
        flushed_d   = 1'b0;
        addr_op_d   = addr_op_q;
        seg_sel_d   = seg_sel_q;
        bus_wdata_d = bus_wdata_q;
        eu_rdata_d  = eu_rdata_q;
        q_push_d    = 1'b0;
        ip_en_d     = 1'b0;
        eu_done_d   = 1'b0;
        arb_s       = 1'b0;
        finish_s    = 1'b0;
        timeout_s   = 1'b0;

        case (state_q)
            BUS_TI: arb_s = 1'b1;
            BUS_T1: state_d = BUS_T2;
            BUS_T2: state_d = BUS_T3;
            BUS_T3: begin
                if (ready) begin
                    finish_s = 1'b1;
                end else begin
                    state_d = BUS_TW;
                    wait_d  = WAIT_W'(1);
                end
            end
            BUS_TW: begin
                if (ready) begin
                    finish_s = 1'b1;
                end else if (wait_q == WAIT_W'(MAX_WAIT)) begin
                    finish_s  = 1'b1;
                    timeout_s = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            BUS_T4: arb_s = 1'b1;
            default: state_d = BUS_TI;
        endcase

        if (finish_s) begin
            state_d = BUS_T4;
            wait_d  = '0;
        end else begin
            wait_d = wait_d;
        end

        if (arb_s && eu_req) begin
            state_d     = BUS_T1;
            wait_d      = '0;
            is_eu_d     = 1'b1;
            we_d        = eu_we;
            addr_op_d   = eu_op;
            seg_sel_d   = eu_seg;
            bus_wdata_d = eu_wdata;
        end else if (arb_s && pf_ok_s) begin
            state_d     = BUS_T1;
            wait_d      = '0;
            is_eu_d     = 1'b0;
            we_d        = 1'b0;
            addr_op_d   = OP_SEG_IP;
            seg_sel_d   = SEG_CS;
            bus_wdata_d = 8'h00;
        end else if (arb_s) begin
            state_d = BUS_TI;
            wait_d  = '0;
            we_d    = 1'b0;
        end else begin
            // A flush seen anywhere in the cycle voids the fetched byte.
            flushed_d = flushed_q | q_flush;
        end

        if (finish_s && is_eu_q) begin
            eu_done_d = 1'b1;
            if (!we_q) begin
                eu_rdata_d = timeout_s ? 8'hFF : bus_rdata;
            end else begin
                eu_rdata_d = eu_rdata_q;
            end
        end else if (finish_s) begin
            q_push_d = !(timeout_s || flushed_q || q_flush);
            ip_en_d  = !(timeout_s || flushed_q || q_flush);
        end else begin
            eu_done_d = 1'b0;
        end

        bus_err_d = timeout_s;
        strobe_s  = (state_d == BUS_T2) || (state_d == BUS_T3) || (state_d == BUS_TW);
        ale_d     = (state_d == BUS_T1);
        rd_n_d    = !(strobe_s && !we_d);
        wr_n_d    = !(strobe_s && we_d);
    end

    // State and output registers; reset abandons any cycle in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= BUS_TI;
            wait_q      <= '0;
            is_eu_q     <= 1'b0;
            we_q        <= 1'b0;
            flushed_q   <= 1'b0;
            addr_op_q   <= 3'b000;
            seg_sel_q   <= 2'b00;
            bus_wdata_q <= 8'h00;
            eu_rdata_q  <= 8'h00;
            ale_q       <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            q_push_q    <= 1'b0;
            ip_en_q     <= 1'b0;
            eu_done_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            is_eu_q     <= is_eu_d;
            we_q        <= we_d;
            flushed_q   <= flushed_d;
            addr_op_q   <= addr_op_d;
            seg_sel_q   <= seg_sel_d;
            bus_wdata_q <= bus_wdata_d;
            eu_rdata_q  <= eu_rdata_d;
            ale_q       <= ale_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            q_push_q    <= q_push_d;
            ip_en_q     <= ip_en_d;
            eu_done_q   <= eu_done_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign bus_state      = state_q;
    assign addr_op        = addr_op_q;
    assign seg_sel        = seg_sel_q;
    assign bus_wdata      = bus_wdata_q;
    assign eu_rdata       = eu_rdata_q;
    assign internal_rd_wr = we_q;
    assign ale            = ale_q;
    assign rd_n           = rd_n_q;
    assign wr_n           = wr_n_q;
    assign q_push         = q_push_q;
    assign ip_en          = ip_en_q;
    assign ip_sel         = 1'b0;
    assign eu_done        = eu_done_q;
    assign bus_err        = bus_err_q;

endmodule
